// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg: shared FSM encoding, counter sizing and WIDTH bounds for the serial subtractor
package serial_sub_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;
  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 64;
  function automatic int cnt_w(input int w);
    return $clog2(w);
  endfunction
endpackage

// File: rtl/subtractor_full.sv
// subtractor_full: one-bit full subtractor cell (d = m - s - bi, bo = borrow out)
module subtractor_full (
  input  logic m,
  input  logic s,
  input  logic bi,
  output logic d,
  output logic bo
);
  assign d  = m ^ s ^ bi;
  assign bo = (~m & s) | (~(m ^ s) & bi);
endmodule

// File: rtl/serial_subtractor_ctrl.sv
// serial_subtractor_ctrl: bit-serial WIDTH-bit subtractor with valid/ready in and out; SERIAL_SUB_ZFLAG_EN enables the zero flag
module serial_subtractor_ctrl
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             zero
);
  localparam int CW = cnt_w(WIDTH);
  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
    $error("serial_subtractor_ctrl: WIDTH out of range");
  end
  state_t state, state_n;
  logic [WIDTH-1:0] a_q, b_q, d_q;
  logic [CW-1:0] cnt;
  logic bf, cell_d, cell_bo, accept, last;
  assign accept = (state == IDLE) && in_valid;
  assign last = cnt == CW'(WIDTH - 1);
  subtractor_full u_cell (.m(a_q[0]), .s(b_q[0]), .bi(bf), .d(cell_d), .bo(cell_bo));
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  // next state: accept -> WIDTH shift cycles -> hold result until consumed
  always_comb begin
    state_n = state;
    state_n = accept ? SHIFT
            : (state == SHIFT && last) ? DONE
            : (state == DONE && out_ready) ? IDLE
            : state;
  end
  // operand load on accept, LSB-first shift with borrow carried between cycles
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
      d_q <= '0;
      cnt <= '0;
      bf  <= 1'b0;
    end else if (accept) begin
      a_q <= a;
      b_q <= b;
      bf  <= borrow_in;
      cnt <= '0;
    end else if (state == SHIFT) begin
      a_q <= a_q >> 1;
      b_q <= b_q >> 1;
      d_q <= {cell_d, d_q[WIDTH-1:1]};
      bf  <= cell_bo;
      cnt <= cnt + 1'b1;
    end
  assign in_ready   = state == IDLE;
  assign out_valid  = state == DONE;
  assign diff       = d_q;
  assign borrow_out = bf;
`ifdef SERIAL_SUB_ZFLAG_EN
  logic acc;
  // OR of every produced diff bit; zero is its complement once the result is complete
  always_ff @(posedge clk or posedge rst)
    if (rst) acc <= 1'b0;
    else if (accept) acc <= 1'b0;
    else if (state == SHIFT) acc <= acc | cell_d;
  assign zero = out_valid & ~acc;
`else
  assign zero = 1'b0;
`endif
endmodule
